// File: rtl/fixed_square.sv
// Signed fixed-point squarer: |x| is squared by an iterative shift-add multiplier
// that retires STEP bits per cycle, and the result is truncated and saturated to Q(WIDTH-FRAC).FRAC.
module fixed_square #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe,
    input  logic [WIDTH-1:0] x,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] square,
    output logic             overflow
);

    localparam int STEPS = WIDTH / STEP;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS);

    typedef enum logic [1:0] {
        READY = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_count;
    logic [WIDTH-1:0]     r_square;
    logic                 r_overflow;
    logic [WIDTH-1:0]     w_abs;
    logic [2*WIDTH-1:0]   w_partial;
    logic                 w_last;
    logic                 w_ovf;

    // Unary minus of the most negative value yields 2^(WIDTH-1), which is correct read as unsigned.
    assign w_abs  = x[WIDTH-1] ? -x : x;
    assign w_last = (r_count == LAST);
    // The scaled product fits iff every bit at weight 2^(WIDTH-1) or above is clear.
    assign w_ovf  = |r_acc[2*WIDTH-1:WIDTH-1+FRAC];

    always_comb begin
        // NOTE: default first so every path assigns, otherwise a latch is inferred.
        w_partial = r_acc;
        for (int j = 0; j < STEP; j++) begin
            if (r_mplier[j]) begin
                w_partial = w_partial + (r_mcand << j);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments only, so all flops update together.
        if (reset) begin
            r_state <= READY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = READY;
        case (r_state)
            READY:   w_next = strobe ? BUSY : READY;
            BUSY:    w_next = w_last ? DONE : BUSY;
            DONE:    w_next = READY;
            default: w_next = READY;
        endcase
    end

    always_comb begin
        ready = (r_state == READY);
        valid = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mplier   <= '0;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_square   <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                READY: begin
                    if (strobe) begin
                        r_mplier <= w_abs;
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs};
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                BUSY: begin
                    if (!w_last) begin
                        r_acc    <= w_partial;
                        r_mplier <= r_mplier >> STEP;
                        r_mcand  <= r_mcand << STEP;
                        r_count  <= r_count + CW'(1);
                    end else begin
                        // Final busy cycle: product is complete, load the result on DONE entry.
                        r_square   <= w_ovf ? {1'b0, {(WIDTH-1){1'b1}}} : r_acc[WIDTH-1+FRAC:FRAC];
                        r_overflow <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign square   = r_square;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_fixed_square.sv
// Scoreboard bench for fixed_square: stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever valid is high.
module tb_fixed_square;

    typedef struct {
        logic [31:0] x;
        logic [31:0] sq;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        strobe = 1'b0;
    logic [31:0] x = '0;
    logic        ready;
    logic        valid;
    logic [31:0] square;
    logic        overflow;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t sb[$];
    vec_t tbl[8];

    fixed_square #(.WIDTH(32), .FRAC(16), .STEP(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .strobe   (strobe),
        .x        (x),
        .ready    (ready),
        .valid    (valid),
        .square   (square),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        vec_t e;
        if (valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got square 0x%0h with no pending request (t=%0t)", square, $time);
            end else begin
                e = sb.pop_front();
                check($sformatf("square x=%h", e.x), 64'(square), 64'(e.sq));
                check($sformatf("overflow x=%h", e.x), 64'(overflow), 64'(e.ovf));
            end
        end
    end

    task automatic do_op(input logic [31:0] xv, input logic [31:0] esq, input logic eovf, input bit noisy);
        int  cnt;
        bit  seen;
        cnt = 0;
        while (!ready && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("ready_before_op", 64'(ready), 64'd1);
        x      = xv;
        strobe = 1'b1;
        sb.push_back('{xv, esq, eovf});
        @(posedge clk);
        #1;
        strobe = 1'b0;
        x      = ~xv;
        seen   = 1'b0;
        cnt    = 0;
        while (!seen && cnt < 30) begin
            @(negedge clk);
            cnt++;
            if (valid) begin
                seen = 1'b1;
            end else if (noisy) begin
                strobe = 1'($urandom_range(0, 1));
                x      = $urandom;
            end
        end
        strobe = 1'b0;
        check($sformatf("latency x=%h", xv), 64'(cnt), 64'd10);
        @(negedge clk);
        check("valid_one_cycle", 64'(valid), 64'd0);
        check("ready_after_done", 64'(ready), 64'd1);
        check("square_hold", 64'(square), 64'(esq));
        check("overflow_hold", 64'(overflow), 64'(eovf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int last_acc;
        int idx;
        int cnt;

        tbl[0] = '{32'h0002_0000, 32'h0004_0000, 1'b0};
        tbl[1] = '{32'hFFFE_8000, 32'h0002_4000, 1'b0};
        tbl[2] = '{32'h00B5_0000, 32'h7FF9_0000, 1'b0};
        tbl[3] = '{32'h0100_0000, 32'h7FFF_FFFF, 1'b1};
        tbl[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        tbl[5] = '{32'h0000_0001, 32'h0000_0000, 1'b0};
        tbl[6] = '{32'h0001_8000, 32'h0002_4000, 1'b0};
        tbl[7] = '{32'hFFFF_0000, 32'h0001_0000, 1'b0};

        // Reset state, with strobe asserted to show reset wins.
        strobe = 1'b1;
        x      = 32'h0002_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_square", 64'(square), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        @(posedge clk);
        #1;
        strobe = 1'b0;
        reset  = 1'b0;

        // First edge after reset accepts immediately.
        do_op(32'h0002_0000, 32'h0004_0000, 1'b0, 1'b0);
        do_op(32'hFFFE_8000, 32'h0002_4000, 1'b0, 1'b1);
        do_op(32'h00B5_0000, 32'h7FF9_0000, 1'b0, 1'b0);
        do_op(32'h0100_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);
        do_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
        do_op(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1);
        do_op(32'h0001_8000, 32'h0002_4000, 1'b0, 1'b0);
        do_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        do_op(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b1);

        // Strobe held high with x changing every cycle.
        @(posedge clk);
        #1;
        idx      = 0;
        x        = tbl[0].x;
        strobe   = 1'b1;
        last_acc = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (ready) begin
                sb.push_back(tbl[idx]);
                if (last_acc >= 0) check("stream_spacing", 64'(cyc - last_acc), 64'd11);
                last_acc = cyc;
            end
            @(posedge clk);
            #1;
            idx = (idx + 1) % 8;
            x   = tbl[idx].x;
        end
        strobe = 1'b0;
        cnt = 0;
        while (sb.size() != 0 && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        check("stream_drained", 64'(sb.size()), 64'd0);

        // Reset during the 4th busy cycle aborts with no valid pulse.
        @(posedge clk);
        #1;
        x      = 32'h0002_0000;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_square", 64'(square), 64'd0);
        check("abort_overflow", 64'(overflow), 64'd0);
        repeat (15) @(negedge clk);
        check("abort_no_pending", 64'(sb.size()), 64'd0);
        do_op(32'h00B5_0000, 32'h7FF9_0000, 1'b0, 1'b0);

        check("final_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
